// File: rtl/counter_pkg.sv
// counter_pkg: shared constants and helpers for the up/down modulo counter.
//   CNT_WRAP / CNT_SAT : end-of-range behaviour selectors for SATURATE.
//   DIR_DOWN / DIR_UP  : encodings of the up_dn input.
//   max_is_legal()     : true when MAX fits 1..2^WIDTH-1 for the given WIDTH.
package counter_pkg;

    localparam bit CNT_WRAP = 1'b0;
    localparam bit CNT_SAT  = 1'b1;

    localparam bit DIR_DOWN = 1'b0;
    localparam bit DIR_UP   = 1'b1;

    function automatic bit max_is_legal(input int unsigned width,
                                        input longint unsigned max_val);
        if ((width < 1) || (width > 32)) begin
            return 1'b0;
        end
        return (max_val >= 64'd1) && (max_val <= ((64'd1 << width) - 64'd1));
    endfunction

endpackage

// File: rtl/counter_next.sv
// counter_next: combinational next-state logic for updown_mod_counter.
//   count      in  current registered count (always within 0..MAX)
//   en         in  step enable
//   up_dn      in  1 = up, 0 = down
//   next_count out value to register when no clear/load is pending
//   wrap_evt   out a step is being taken from a range end (sets sticky ovf)
//   tc         out terminal count, zero latency, usable as a cascade enable
module counter_next
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned MAX      = 15,
    parameter bit          SATURATE = CNT_WRAP
) (
    input  logic [WIDTH-1:0] count,
    input  logic             en,
    input  logic             up_dn,
    output logic [WIDTH-1:0] next_count,
    output logic             wrap_evt,
    output logic             tc
);

    localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX);

    logic at_top;
    logic at_bot;

    always_comb begin
        at_top = (count == MAX_W);
        at_bot = (count == '0);

        tc = en & (((up_dn == DIR_UP) & at_top) | ((up_dn == DIR_DOWN) & at_bot));
        // Stepping off either end flags overflow in both wrap and saturate modes.
        wrap_evt = tc;

        next_count = count;
        if (en) begin
            if (up_dn == DIR_UP) begin
                if (at_top) begin
                    next_count = (SATURATE == CNT_SAT) ? MAX_W : '0;
                end else begin
                    next_count = count + 1'b1;
                end
            end else begin
                if (at_bot) begin
                    next_count = (SATURATE == CNT_SAT) ? '0 : MAX_W;
                end else begin
                    next_count = count - 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/updown_mod_counter.sv
// updown_mod_counter: parametrised up/down modulo counter with clear, load,
// wrap/saturate ends, terminal count and sticky overflow.
//   clk      in   rising-edge clock
//   resetn   in   synchronous active-low reset
//   en       in   count enable, one step per enabled cycle
//   up_dn    in   1 = up, 0 = down
//   clr      in   synchronous clear of count and ovf
//   load     in   synchronous load of load_val (clamped to MAX)
//   load_val in   load value
//   count    out  registered count, range 0..MAX
//   tc       out  combinational terminal count
//   ovf      out  registered sticky overflow/underflow flag
// Edge priority: resetn low > clr > load > en > hold.
module updown_mod_counter
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned MAX      = 15,
    parameter bit          SATURATE = CNT_WRAP
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             en,
    input  logic             up_dn,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             ovf
);

    generate
        if (!max_is_legal(WIDTH, MAX)) begin : g_bad_max
            $error("updown_mod_counter: MAX=%0d illegal for WIDTH=%0d", MAX, WIDTH);
        end
    endgenerate

    localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX);

    logic [WIDTH-1:0] next_count;
    logic             wrap_evt;
    logic [WIDTH-1:0] load_clamped;

    // Clamping on load keeps count inside 0..MAX, so counter_next never
    // has to handle out-of-range values.
    always_comb begin
        load_clamped = (load_val > MAX_W) ? MAX_W : load_val;
    end

    counter_next #(
        .WIDTH    (WIDTH),
        .MAX      (MAX),
        .SATURATE (SATURATE)
    ) u_next (
        .count      (count),
        .en         (en),
        .up_dn      (up_dn),
        .next_count (next_count),
        .wrap_evt   (wrap_evt),
        .tc         (tc)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            count <= '0;
            ovf   <= 1'b0;
        end else if (clr) begin
            count <= '0;
            ovf   <= 1'b0;
        end else if (load) begin
            count <= load_clamped;
        end else begin
            count <= next_count;
            if (wrap_evt) begin
                ovf <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_updown_mod_counter.sv
// tb_updown_mod_counter: self-checking bench for updown_mod_counter.
// Instances: u_a default (MAX=15 wrap), u_b MAX=9 wrap, u_c MAX=5 saturate,
// u_lo/u_hi a two-digit decimal cascade. Inputs are shared; each scenario
// first puts its own instance into a known state.
module tb_updown_mod_counter;

    logic       clk = 1'b0;
    logic       resetn, en, up_dn, clr, load;
    logic [3:0] load_val;

    logic [3:0] a_count, b_count, c_count, lo_count, hi_count;
    logic       a_tc, b_tc, c_tc, lo_tc, hi_tc;
    logic       a_ovf, b_ovf, c_ovf, lo_ovf, hi_ovf;

    typedef struct packed {
        logic [3:0] count;
        logic       ovf;
        logic       tc;
    } exp_t;

    exp_t sbq[$];
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    updown_mod_counter #(.WIDTH(4), .MAX(15), .SATURATE(1'b0)) u_a (
        .clk(clk), .resetn(resetn), .en(en), .up_dn(up_dn), .clr(clr), .load(load),
        .load_val(load_val), .count(a_count), .tc(a_tc), .ovf(a_ovf));

    updown_mod_counter #(.WIDTH(4), .MAX(9), .SATURATE(1'b0)) u_b (
        .clk(clk), .resetn(resetn), .en(en), .up_dn(up_dn), .clr(clr), .load(load),
        .load_val(load_val), .count(b_count), .tc(b_tc), .ovf(b_ovf));

    updown_mod_counter #(.WIDTH(4), .MAX(5), .SATURATE(1'b1)) u_c (
        .clk(clk), .resetn(resetn), .en(en), .up_dn(up_dn), .clr(clr), .load(load),
        .load_val(load_val), .count(c_count), .tc(c_tc), .ovf(c_ovf));

    updown_mod_counter #(.WIDTH(4), .MAX(9), .SATURATE(1'b0)) u_lo (
        .clk(clk), .resetn(resetn), .en(en), .up_dn(up_dn), .clr(clr), .load(load),
        .load_val(load_val), .count(lo_count), .tc(lo_tc), .ovf(lo_ovf));

    updown_mod_counter #(.WIDTH(4), .MAX(9), .SATURATE(1'b0)) u_hi (
        .clk(clk), .resetn(resetn), .en(lo_tc), .up_dn(up_dn), .clr(clr), .load(load),
        .load_val(load_val), .count(hi_count), .tc(hi_tc), .ovf(hi_ovf));

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic r, input logic e, input logic u,
                         input logic c, input logic l, input logic [3:0] lv);
        resetn   = r;
        en       = e;
        up_dn    = u;
        clr      = c;
        load     = l;
        load_val = lv;
    endtask

    task automatic test_reset();
        exp_t e;
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
        repeat (3) tick();
        checks++;
        if (a_count !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", a_count); end
        checks++;
        if (a_ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %0b expected 0", a_ovf); end
        checks++;
        if (a_tc !== 1'b0) begin errors++; $display("FAIL reset_tc: got %0b expected 0", a_tc); end

        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
        for (int i = 1; i <= 15; i++) begin
            sbq.push_back('{count: 4'(i), ovf: 1'b0, tc: (i == 15)});
        end
        sbq.push_back('{count: 4'd0, ovf: 1'b1, tc: 1'b0});
        while (sbq.size() > 0) begin
            tick();
            e = sbq.pop_front();
            checks++;
            if (a_count !== e.count) begin errors++; $display("FAIL up_count: got %0d expected %0d", a_count, e.count); end
            checks++;
            if (a_ovf !== e.ovf) begin errors++; $display("FAIL up_ovf: got %0b expected %0b (count %0d)", a_ovf, e.ovf, e.count); end
            checks++;
            if (a_tc !== e.tc) begin errors++; $display("FAIL up_tc: got %0b expected %0b (count %0d)", a_tc, e.tc, e.count); end
        end
    endtask

    task automatic test_down_wrap();
        exp_t e;
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
        tick();
        checks++;
        if (b_count !== 4'd0 || b_ovf !== 1'b0) begin
            errors++; $display("FAIL down_clr: got count=%0d ovf=%0b expected 0/0", b_count, b_ovf);
        end
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        #1;
        checks++;
        if (b_tc !== 1'b1) begin errors++; $display("FAIL down_tc_at0: got %0b expected 1", b_tc); end

        sbq.push_back('{count: 4'd9, ovf: 1'b1, tc: 1'b0});
        for (int v = 8; v >= 0; v--) begin
            sbq.push_back('{count: 4'(v), ovf: 1'b1, tc: (v == 0)});
        end
        while (sbq.size() > 0) begin
            tick();
            e = sbq.pop_front();
            checks++;
            if (b_count !== e.count) begin errors++; $display("FAIL down_count: got %0d expected %0d", b_count, e.count); end
            checks++;
            if (b_ovf !== e.ovf) begin errors++; $display("FAIL down_ovf: got %0b expected %0b", b_ovf, e.ovf); end
            checks++;
            if (b_tc !== e.tc) begin errors++; $display("FAIL down_tc: got %0b expected %0b (count %0d)", b_tc, e.tc, e.count); end
        end
    endtask

    task automatic test_saturate();
        exp_t e;
        drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
        tick();
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 4'd4);
        tick();
        checks++;
        if (c_count !== 4'd4 || c_ovf !== 1'b0) begin
            errors++; $display("FAIL sat_load: got count=%0d ovf=%0b expected 4/0", c_count, c_ovf);
        end
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
        sbq.push_back('{count: 4'd5, ovf: 1'b0, tc: 1'b1});
        sbq.push_back('{count: 4'd5, ovf: 1'b1, tc: 1'b1});
        sbq.push_back('{count: 4'd5, ovf: 1'b1, tc: 1'b1});
        for (int k = 0; k < 4; k++) begin
            if (k == 3) begin
                drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
                sbq.push_back('{count: 4'd4, ovf: 1'b1, tc: 1'b0});
            end
            tick();
            e = sbq.pop_front();
            checks++;
            if (c_count !== e.count) begin errors++; $display("FAIL sat_count: step %0d got %0d expected %0d", k, c_count, e.count); end
            checks++;
            if (c_ovf !== e.ovf) begin errors++; $display("FAIL sat_ovf: step %0d got %0b expected %0b", k, c_ovf, e.ovf); end
            checks++;
            if (c_tc !== e.tc) begin errors++; $display("FAIL sat_tc: step %0d got %0b expected %0b", k, c_tc, e.tc); end
        end
    endtask

    task automatic test_priority();
        typedef struct packed {
            logic r, e, u, c, l;
            logic [3:0] lv;
        } stim_t;
        stim_t st[7];
        exp_t  ex[7];
        exp_t  e;
        st[0] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0};   ex[0] = '{4'd0, 1'b0, 1'b0};
        st[1] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 4'd13};  ex[1] = '{4'd9, 1'b0, 1'b0};
        st[2] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0};   ex[2] = '{4'd0, 1'b1, 1'b0};
        st[3] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 4'd3};   ex[3] = '{4'd3, 1'b1, 1'b0};
        st[4] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 4'd7};   ex[4] = '{4'd0, 1'b0, 1'b0};
        st[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 4'd8};   ex[5] = '{4'd8, 1'b0, 1'b0};
        st[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd5};   ex[6] = '{4'd0, 1'b0, 1'b0};
        for (int k = 0; k < 7; k++) begin
            drive(st[k].r, st[k].e, st[k].u, st[k].c, st[k].l, st[k].lv);
            sbq.push_back(ex[k]);
            tick();
            e = sbq.pop_front();
            checks++;
            if (b_count !== e.count) begin errors++; $display("FAIL prio_count: step %0d got %0d expected %0d", k, b_count, e.count); end
            checks++;
            if (b_ovf !== e.ovf) begin errors++; $display("FAIL prio_ovf: step %0d got %0b expected %0b", k, b_ovf, e.ovf); end
        end
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
    endtask

    task automatic test_cascade();
        exp_t el, eh;
        drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
        tick();
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
        sbq.push_back('{count: 4'd7, ovf: 1'b1, tc: 1'b0});
        sbq.push_back('{count: 4'd3, ovf: 1'b0, tc: 1'b0});
        sbq.push_back('{count: 4'd0, ovf: 1'b1, tc: 1'b0});
        sbq.push_back('{count: 4'd0, ovf: 1'b1, tc: 1'b0});
        for (int m = 0; m < 2; m++) begin
            repeat ((m == 0) ? 37 : 63) tick();
            el = sbq.pop_front();
            eh = sbq.pop_front();
            checks++;
            if (lo_count !== el.count) begin errors++; $display("FAIL cas_lo_count: mark %0d got %0d expected %0d", m, lo_count, el.count); end
            checks++;
            if (hi_count !== eh.count) begin errors++; $display("FAIL cas_hi_count: mark %0d got %0d expected %0d", m, hi_count, eh.count); end
            checks++;
            if (lo_ovf !== el.ovf) begin errors++; $display("FAIL cas_lo_ovf: mark %0d got %0b expected %0b", m, lo_ovf, el.ovf); end
            checks++;
            if (hi_ovf !== eh.ovf) begin errors++; $display("FAIL cas_hi_ovf: mark %0d got %0b expected %0b", m, hi_ovf, eh.ovf); end
            checks++;
            if (hi_tc !== eh.tc) begin errors++; $display("FAIL cas_hi_tc: mark %0d got %0b expected %0b", m, hi_tc, eh.tc); end
        end
    endtask

    task automatic test_hold_dir();
        exp_t e;
        drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
        tick();
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 4'd6);
        tick();
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
        for (int k = 0; k < 5; k++) begin
            sbq.push_back('{count: 4'd6, ovf: 1'b0, tc: 1'b0});
        end
        for (int k = 0; k < 4; k++) begin
            sbq.push_back('{count: (k % 2 == 0) ? 4'd7 : 4'd6, ovf: 1'b0, tc: 1'b0});
        end
        for (int k = 0; k < 9; k++) begin
            if (k >= 5) begin
                drive(1'b1, 1'b1, ((k - 5) % 2 == 0), 1'b0, 1'b0, 4'd0);
            end
            tick();
            e = sbq.pop_front();
            checks++;
            if (b_count !== e.count) begin errors++; $display("FAIL hold_dir_count: step %0d got %0d expected %0d", k, b_count, e.count); end
            checks++;
            if (b_ovf !== e.ovf) begin errors++; $display("FAIL hold_dir_ovf: step %0d got %0b expected %0b", k, b_ovf, e.ovf); end
            checks++;
            if (b_tc !== e.tc) begin errors++; $display("FAIL hold_dir_tc: step %0d got %0b expected %0b", k, b_tc, e.tc); end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
        test_reset();
        test_down_wrap();
        test_saturate();
        test_priority();
        test_cascade();
        test_hold_dir();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
